// File: rtl/mc_ctrl_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// opcode/funct values, datapath control codes and the decoder output record.
package mc_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_DCD  = 3'd1,
        S_EXE  = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_MDU  = 3'd5,
        S_HALT = 3'd6
    } state_t;

    // Primary opcodes
    localparam logic [5:0] op_rtype  = 6'h00;
    localparam logic [5:0] op_regimm = 6'h01;
    localparam logic [5:0] op_j      = 6'h02;
    localparam logic [5:0] op_jal    = 6'h03;
    localparam logic [5:0] op_beq    = 6'h04;
    localparam logic [5:0] op_blez   = 6'h06;
    localparam logic [5:0] op_bgtz   = 6'h07;
    localparam logic [5:0] op_slti   = 6'h0A;
    localparam logic [5:0] op_ori    = 6'h0D;
    localparam logic [5:0] op_lui    = 6'h0F;
    localparam logic [5:0] op_lw     = 6'h23;
    localparam logic [5:0] op_lbu    = 6'h24;
    localparam logic [5:0] op_lhu    = 6'h25;
    localparam logic [5:0] op_sb     = 6'h28;
    localparam logic [5:0] op_sh     = 6'h29;
    localparam logic [5:0] op_sw     = 6'h2B;

    // R-type functs
    localparam logic [5:0] fn_sll   = 6'h00;
    localparam logic [5:0] fn_jr    = 6'h08;
    localparam logic [5:0] fn_jalr  = 6'h09;
    localparam logic [5:0] fn_mfhi  = 6'h10;
    localparam logic [5:0] fn_mflo  = 6'h12;
    localparam logic [5:0] fn_mult  = 6'h18;
    localparam logic [5:0] fn_multu = 6'h19;
    localparam logic [5:0] fn_div   = 6'h1A;
    localparam logic [5:0] fn_divu  = 6'h1B;
    localparam logic [5:0] fn_addu  = 6'h21;
    localparam logic [5:0] fn_subu  = 6'h23;
    localparam logic [5:0] fn_slt   = 6'h2A;

    // REGIMM rt selectors
    localparam logic [4:0] rt_bltz = 5'd0;
    localparam logic [4:0] rt_bgez = 5'd1;

    // Datapath control codes
    localparam logic [1:0] npc_pc4 = 2'd0;
    localparam logic [1:0] npc_16  = 2'd1;
    localparam logic [1:0] npc_26  = 2'd2;
    localparam logic [1:0] npc_reg = 2'd3;

    localparam logic [1:0] ext_zero = 2'd0;
    localparam logic [1:0] ext_sign = 2'd1;
    localparam logic [1:0] ext_lui  = 2'd2;

    localparam logic [1:0] alu_add = 2'd0;
    localparam logic [1:0] alu_sub = 2'd1;
    localparam logic [1:0] alu_or  = 2'd2;
    localparam logic [1:0] alu_sll = 2'd3;

    localparam logic alusrc_reg = 1'b0;
    localparam logic alusrc_imm = 1'b1;

    localparam logic [1:0] regdst_rt = 2'd0;
    localparam logic [1:0] regdst_rd = 2'd1;
    localparam logic [1:0] regdst_31 = 2'd2;

    localparam logic [2:0] mtr_alu = 3'd0;
    localparam logic [2:0] mtr_dm  = 3'd1;
    localparam logic [2:0] mtr_pc4 = 3'd2;
    localparam logic [2:0] mtr_slt = 3'd3;
    localparam logic [2:0] mtr_hi  = 3'd4;
    localparam logic [2:0] mtr_lo  = 3'd5;

    // Static decode of one instruction: datapath fields plus class bits
    typedef struct packed {
        logic [1:0] npcop;
        logic [1:0] extop;
        logic [1:0] aluop;
        logic       alusrc;
        logic [1:0] regdst;
        logic [2:0] memtoreg;
        logic       hf;
        logic       bt;
        logic       is_jump;
        logic       is_branch;
        logic       is_load;
        logic       is_store;
        logic       is_mdu;
        logic       is_div;
        logic       link;
        logic       unknown;
    } dec_t;

    // Instructions that need a data-memory state
    function automatic logic is_mem(input dec_t d);
        return d.is_load | d.is_store;
    endfunction

endpackage

// File: rtl/mc_ctrl_dec.sv
// mc_dec: purely combinational instruction decoder. Maps the IR contents to
// the static datapath fields and the class bits used by the sequencer.
module mc_dec
    import mc_ctrl_pkg::*;
(
    input  logic [31:0] instr,
    output dec_t        dec
);

    logic [5:0] op_s;
    logic [5:0] funct_s;
    logic [4:0] rt_s;
    logic       unused_s;

    assign op_s     = instr[31:26];
    assign funct_s  = instr[5:0];
    assign rt_s     = instr[20:16];
    assign unused_s = ^{instr[25:21], instr[15:6]};

    // Opcode/funct lookup; anything not listed is flagged unknown with all fields 0
    always_comb begin
        dec = '0;
        case (op_s)
            op_rtype: begin
                case (funct_s)
                    fn_sll:  begin dec.aluop = alu_sll; dec.regdst = regdst_rd; end
                    fn_addu: begin dec.aluop = alu_add; dec.regdst = regdst_rd; end
                    fn_subu: begin dec.aluop = alu_sub; dec.regdst = regdst_rd; end
                    fn_slt:  begin dec.aluop = alu_sub; dec.regdst = regdst_rd; dec.memtoreg = mtr_slt; end
                    fn_mfhi: begin dec.regdst = regdst_rd; dec.memtoreg = mtr_hi; end
                    fn_mflo: begin dec.regdst = regdst_rd; dec.memtoreg = mtr_lo; end
                    fn_jr:   begin dec.npcop = npc_reg; dec.is_jump = 1'b1; end
                    fn_jalr: begin
                        dec.npcop    = npc_reg;
                        dec.regdst   = regdst_rd;
                        dec.memtoreg = mtr_pc4;
                        dec.is_jump  = 1'b1;
                        dec.link     = 1'b1;
                    end
                    fn_mult, fn_multu: dec.is_mdu = 1'b1;
                    fn_div, fn_divu:   begin dec.is_mdu = 1'b1; dec.is_div = 1'b1; end
                    default: dec.unknown = 1'b1;
                endcase
            end
            op_regimm: begin
                if ((rt_s == rt_bltz) || (rt_s == rt_bgez)) begin
                    dec.npcop     = npc_16;
                    dec.extop     = ext_sign;
                    dec.aluop     = alu_sub;
                    dec.is_branch = 1'b1;
                end else begin
                    dec.unknown = 1'b1;
                end
            end
            op_beq, op_blez, op_bgtz: begin
                dec.npcop     = npc_16;
                dec.extop     = ext_sign;
                dec.aluop     = alu_sub;
                dec.is_branch = 1'b1;
            end
            op_j:   begin dec.npcop = npc_26; dec.is_jump = 1'b1; end
            op_jal: begin
                dec.npcop    = npc_26;
                dec.regdst   = regdst_31;
                dec.memtoreg = mtr_pc4;
                dec.is_jump  = 1'b1;
                dec.link     = 1'b1;
            end
            op_ori:  begin dec.extop = ext_zero; dec.aluop = alu_or;  dec.alusrc = alusrc_imm; end
            op_slti: begin dec.extop = ext_sign; dec.aluop = alu_sub; dec.alusrc = alusrc_imm; dec.memtoreg = mtr_slt; end
            op_lui:  begin dec.extop = ext_lui;  dec.aluop = alu_or;  dec.alusrc = alusrc_imm; end
            op_lw, op_lbu, op_lhu: begin
                dec.extop    = ext_sign;
                dec.alusrc   = alusrc_imm;
                dec.memtoreg = mtr_dm;
                dec.hf       = (op_s == op_lhu);
                dec.bt       = (op_s == op_lbu);
                dec.is_load  = 1'b1;
            end
            op_sw, op_sh, op_sb: begin
                dec.extop    = ext_sign;
                dec.alusrc   = alusrc_imm;
                dec.hf       = (op_s == op_sh);
                dec.bt       = (op_s == op_sb);
                dec.is_store = 1'b1;
            end
            default: dec.unknown = 1'b1;
        endcase
    end

endmodule

// File: rtl/mc_ctrl.sv
// mc_ctrl: multi-cycle MIPS control unit. Holds the state register, the
// multiply/divide wait counter and the per-state strobe logic; static fields
// come from mc_dec. Optional macro MC_CTRL_RI_EXC_EN turns unknown
// instructions into a reserved-instruction halt instead of a nop.
module mc_ctrl
    import mc_ctrl_pkg::*;
#(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 5
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic        cmp_true,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  npcop,
    output logic [1:0]  extop,
    output logic [1:0]  aluop,
    output logic        alusrc,
    output logic [1:0]  regdst,
    output logic [2:0]  memtoreg,
    output logic        hf,
    output logic        bt,
    output logic        mdu_start,
    output logic        hilo_we,
    output logic [2:0]  state,
    output logic        ri_exc
);

    localparam logic [CNT_W-1:0] mult_last_c = CNT_W'(MULT_LAT - 1);
    localparam logic [CNT_W-1:0] div_last_c  = CNT_W'(DIV_LAT - 1);
    localparam logic [CNT_W-1:0] cnt_one_c   = CNT_W'(1);

    state_t           state_r, state_next_s;
    logic [CNT_W-1:0] cnt_r, cnt_next_s, lat_last_s;
    dec_t             dec_s;
    logic             pc_we_s, ir_we_s, reg_we_s, mem_we_s;
    logic             mdu_start_s, hilo_we_s, ri_exc_s;

    mc_dec u_dec (
        .instr (instr),
        .dec   (dec_s)
    );

    assign lat_last_s = dec_s.is_div ? div_last_c : mult_last_c;
    assign state      = state_r;

    // State register and MDU counter, synchronous reset to a clean fetch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= S_IF;
            cnt_r   <= '0;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state and raw strobe decode per state
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        pc_we_s      = 1'b0;
        ir_we_s      = 1'b0;
        reg_we_s     = 1'b0;
        mem_we_s     = 1'b0;
        mdu_start_s  = 1'b0;
        hilo_we_s    = 1'b0;
        ri_exc_s     = 1'b0;
        case (state_r)
            S_IF: begin
                ir_we_s      = 1'b1;
                pc_we_s      = 1'b1;
                state_next_s = S_DCD;
            end
            S_DCD: begin
                if (dec_s.unknown) begin
`ifdef MC_CTRL_RI_EXC_EN
                    ri_exc_s     = 1'b1;
                    state_next_s = S_HALT;
`else
                    state_next_s = S_IF;
`endif
                end else if (dec_s.is_jump) begin
                    // link writes the PC already incremented in S_IF
                    pc_we_s      = 1'b1;
                    reg_we_s     = dec_s.link;
                    state_next_s = S_IF;
                end else begin
                    state_next_s = S_EXE;
                end
            end
            S_EXE: begin
                if (dec_s.is_branch) begin
                    pc_we_s      = cmp_true;
                    state_next_s = S_IF;
                end else if (dec_s.is_mdu) begin
                    mdu_start_s  = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = S_MDU;
                end else if (is_mem(dec_s)) begin
                    state_next_s = S_MEM;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_MDU: begin
                if (cnt_r == lat_last_s) begin
                    hilo_we_s    = 1'b1;
                    cnt_next_s   = '0;
                    state_next_s = S_IF;
                end else begin
                    cnt_next_s   = cnt_r + cnt_one_c;
                end
            end
            S_MEM: begin
                if (dec_s.is_store) begin
                    mem_we_s     = 1'b1;
                    state_next_s = S_IF;
                end else begin
                    state_next_s = S_WB;
                end
            end
            S_WB: begin
                reg_we_s     = 1'b1;
                state_next_s = S_IF;
            end
            S_HALT: begin
`ifdef MC_CTRL_RI_EXC_EN
                state_next_s = S_HALT;
`else
                state_next_s = S_IF;
`endif
            end
            default: state_next_s = S_IF;
        endcase
    end

    // Strobe outputs, forced low while reset is held
    always_comb begin
        if (reset) begin
            pc_we     = 1'b0;
            ir_we     = 1'b0;
            reg_we    = 1'b0;
            mem_we    = 1'b0;
            mdu_start = 1'b0;
            hilo_we   = 1'b0;
            ri_exc    = 1'b0;
        end else begin
            pc_we     = pc_we_s;
            ir_we     = ir_we_s;
            reg_we    = reg_we_s;
            mem_we    = mem_we_s;
            mdu_start = mdu_start_s;
            hilo_we   = hilo_we_s;
            ri_exc    = ri_exc_s;
        end
    end

    // Static field outputs; NPC selects PC+4 while fetching, all zero in reset
    always_comb begin
        if (reset) begin
            npcop    = npc_pc4;
            extop    = 2'd0;
            aluop    = 2'd0;
            alusrc   = 1'b0;
            regdst   = 2'd0;
            memtoreg = 3'd0;
            hf       = 1'b0;
            bt       = 1'b0;
        end else begin
            npcop    = (state_r == S_IF) ? npc_pc4 : dec_s.npcop;
            extop    = dec_s.extop;
            aluop    = dec_s.aluop;
            alusrc   = dec_s.alusrc;
            regdst   = dec_s.regdst;
            memtoreg = dec_s.memtoreg;
            hf       = dec_s.hf;
            bt       = dec_s.bt;
        end
    end

endmodule

// File: tb/tb_mc_ctrl.sv
// Randomised scoreboard bench for mc_ctrl. The driver expands each issued
// instruction into its expected per-cycle trace from the instruction class
// rules and queues it; a negedge monitor pops and compares every cycle.
module tb_mc_ctrl;
    import mc_ctrl_pkg::*;

    localparam int MULT_LAT = 5;
    localparam int DIV_LAT  = 10;
    localparam int CNT_W    = 5;

    localparam int C_ALU = 0, C_LOAD = 1, C_STORE = 2, C_BR = 3, C_J = 4;
    localparam int C_JL = 5, C_MULT = 6, C_DIV = 7, C_UNK = 8;
    localparam int N_INS = 29;

    logic        clk = 1'b0, reset = 1'b1, cmp_true = 1'b0;
    logic [31:0] instr = 32'h0;
    logic        pc_we, ir_we, reg_we, mem_we, alusrc, hf, bt, mdu_start, hilo_we, ri_exc;
    logic [1:0]  npcop, extop, aluop, regdst;
    logic [2:0]  memtoreg, state;

    mc_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .instr(instr), .cmp_true(cmp_true),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
        .npcop(npcop), .extop(extop), .aluop(aluop), .alusrc(alusrc),
        .regdst(regdst), .memtoreg(memtoreg), .hf(hf), .bt(bt),
        .mdu_start(mdu_start), .hilo_we(hilo_we), .state(state), .ri_exc(ri_exc)
    );

    always #5 clk = ~clk;

    // stb = {pc_we, ir_we, reg_we, mem_we, mdu_start, hilo_we, ri_exc}
    typedef struct packed {
        logic [2:0]  st;
        logic [6:0]  stb;
        logic [13:0] fld;
        logic [15:0] tag;
    } rec_t;

    typedef struct {
        int          cls;
        logic [31:0] base;
        logic [31:0] mask;
        logic [13:0] fld;
    } ins_t;

    ins_t        tab [N_INS];
    rec_t        exp_q [$];
    int          n_cmp = 0, n_bad = 0;
    logic        running = 1'b0;
    logic [15:0] tag = 16'd0;

    function automatic logic [13:0] fl(input logic [1:0] npc, input logic [1:0] ext,
                                       input logic [1:0] alu, input logic src,
                                       input logic [1:0] rd, input logic [2:0] mtr,
                                       input logic h, input logic b);
        return {npc, ext, alu, src, rd, mtr, h, b};
    endfunction

    function automatic rec_t mk(input logic [2:0] st, input logic [6:0] stb, input logic [13:0] f);
        rec_t r;
        r.st = st; r.stb = stb; r.fld = f; r.tag = tag;
        return r;
    endfunction

    function automatic logic [31:0] enc(input int idx);
        return tab[idx].base | ($urandom() & tab[idx].mask);
    endfunction

    task automatic fill_tab();
        localparam logic [31:0] MR = 32'h03FF_FFC0, MI = 32'h03FF_FFFF, MB = 32'h03E0_FFFF;
        tab[0]  = '{C_ALU,   32'h0000_0021, MR, fl(npc_pc4, ext_zero, alu_add, 1'b0, regdst_rd, mtr_alu, 1'b0, 1'b0)};
        tab[1]  = '{C_ALU,   32'h0000_0023, MR, fl(npc_pc4, ext_zero, alu_sub, 1'b0, regdst_rd, mtr_alu, 1'b0, 1'b0)};
        tab[2]  = '{C_ALU,   32'h0000_002A, MR, fl(npc_pc4, ext_zero, alu_sub, 1'b0, regdst_rd, mtr_slt, 1'b0, 1'b0)};
        tab[3]  = '{C_ALU,   32'h0000_0000, MR, fl(npc_pc4, ext_zero, alu_sll, 1'b0, regdst_rd, mtr_alu, 1'b0, 1'b0)};
        tab[4]  = '{C_ALU,   32'h0000_0010, MR, fl(npc_pc4, ext_zero, alu_add, 1'b0, regdst_rd, mtr_hi,  1'b0, 1'b0)};
        tab[5]  = '{C_ALU,   32'h0000_0012, MR, fl(npc_pc4, ext_zero, alu_add, 1'b0, regdst_rd, mtr_lo,  1'b0, 1'b0)};
        tab[6]  = '{C_ALU,   32'h3400_0000, MI, fl(npc_pc4, ext_zero, alu_or,  1'b1, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[7]  = '{C_ALU,   32'h2800_0000, MI, fl(npc_pc4, ext_sign, alu_sub, 1'b1, regdst_rt, mtr_slt, 1'b0, 1'b0)};
        tab[8]  = '{C_ALU,   32'h3C00_0000, MI, fl(npc_pc4, ext_lui,  alu_or,  1'b1, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[9]  = '{C_LOAD,  32'h8C00_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_dm,  1'b0, 1'b0)};
        tab[10] = '{C_LOAD,  32'h9000_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_dm,  1'b0, 1'b1)};
        tab[11] = '{C_LOAD,  32'h9400_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_dm,  1'b1, 1'b0)};
        tab[12] = '{C_STORE, 32'hAC00_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[13] = '{C_STORE, 32'hA400_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_alu, 1'b1, 1'b0)};
        tab[14] = '{C_STORE, 32'hA000_0000, MI, fl(npc_pc4, ext_sign, alu_add, 1'b1, regdst_rt, mtr_alu, 1'b0, 1'b1)};
        tab[15] = '{C_BR,    32'h1000_0000, MI, fl(npc_16,  ext_sign, alu_sub, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[16] = '{C_BR,    32'h1800_0000, MI, fl(npc_16,  ext_sign, alu_sub, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[17] = '{C_BR,    32'h1C00_0000, MI, fl(npc_16,  ext_sign, alu_sub, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[18] = '{C_BR,    32'h0400_0000, MB, fl(npc_16,  ext_sign, alu_sub, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[19] = '{C_BR,    32'h0401_0000, MB, fl(npc_16,  ext_sign, alu_sub, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[20] = '{C_J,     32'h0800_0000, MI, fl(npc_26,  ext_zero, alu_add, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[21] = '{C_JL,    32'h0C00_0000, MI, fl(npc_26,  ext_zero, alu_add, 1'b0, regdst_31, mtr_pc4, 1'b0, 1'b0)};
        tab[22] = '{C_J,     32'h0000_0008, MR, fl(npc_reg, ext_zero, alu_add, 1'b0, regdst_rt, mtr_alu, 1'b0, 1'b0)};
        tab[23] = '{C_JL,    32'h0000_0009, MR, fl(npc_reg, ext_zero, alu_add, 1'b0, regdst_rd, mtr_pc4, 1'b0, 1'b0)};
        tab[24] = '{C_MULT,  32'h0000_0018, MR, 14'h0};
        tab[25] = '{C_MULT,  32'h0000_0019, MR, 14'h0};
        tab[26] = '{C_DIV,   32'h0000_001A, MR, 14'h0};
        tab[27] = '{C_DIV,   32'h0000_001B, MR, 14'h0};
        tab[28] = '{C_UNK,   32'hFC00_0000, MI, 14'h0};
    endtask

    // Issue one instruction at the start of an S_IF cycle, queue its expected
    // trace, and optionally pulse reset during cycle rst_at of that trace.
    task automatic run_instr(input int idx, input logic [31:0] e, input logic cmp, input int rst_at);
        rec_t        seq [$];
        rec_t        r;
        int          cls, lat, ra;
        logic [13:0] f;
        cls = tab[idx].cls;
        f   = tab[idx].fld;
        ra  = rst_at;
        tag = tag + 16'd1;
        instr    = e;
        cmp_true = cmp;
        seq.push_back(mk(S_IF, 7'b1100000, f & 14'h0FFF));
        case (cls)
            C_J:  seq.push_back(mk(S_DCD, 7'b1000000, f));
            C_JL: seq.push_back(mk(S_DCD, 7'b1010000, f));
            C_UNK: begin
`ifdef MC_CTRL_RI_EXC_EN
                seq.push_back(mk(S_DCD, 7'b0000001, f));
                for (int k = 0; k < 3; k++) seq.push_back(mk(S_HALT, 7'b0, f));
                ra = 4;
`else
                seq.push_back(mk(S_DCD, 7'b0, f));
`endif
            end
            default: begin
                seq.push_back(mk(S_DCD, 7'b0, f));
                case (cls)
                    C_BR: seq.push_back(mk(S_EXE, {cmp, 6'b0}, f));
                    C_ALU: begin
                        seq.push_back(mk(S_EXE, 7'b0, f));
                        seq.push_back(mk(S_WB, 7'b0010000, f));
                    end
                    C_STORE: begin
                        seq.push_back(mk(S_EXE, 7'b0, f));
                        seq.push_back(mk(S_MEM, 7'b0001000, f));
                    end
                    C_LOAD: begin
                        seq.push_back(mk(S_EXE, 7'b0, f));
                        seq.push_back(mk(S_MEM, 7'b0, f));
                        seq.push_back(mk(S_WB, 7'b0010000, f));
                    end
                    C_MULT, C_DIV: begin
                        lat = (cls == C_DIV) ? DIV_LAT : MULT_LAT;
                        seq.push_back(mk(S_EXE, 7'b0000100, f));
                        for (int k = 0; k < lat - 1; k++) seq.push_back(mk(S_MDU, 7'b0, f));
                        seq.push_back(mk(S_MDU, 7'b0000010, f));
                    end
                    default: ;
                endcase
            end
        endcase
        if (ra >= 0 && ra < seq.size()) begin
            r = seq[ra];
            r.stb = 7'b0;
            r.fld = 14'h0;
            while (seq.size() > ra) void'(seq.pop_back());
            seq.push_back(r);
        end else begin
            ra = -1;
        end
        foreach (seq[i]) exp_q.push_back(seq[i]);
        if (ra < 0) begin
            repeat (seq.size()) @(posedge clk);
        end else begin
            repeat (ra) @(posedge clk);
            #1 reset = 1'b1;
            @(posedge clk);
        end
        #1 reset = 1'b0;
    endtask

    // Monitor: one expected record per cycle while the scoreboard is live
    always @(negedge clk) begin
        rec_t        e;
        logic [23:0] got;
        if (running) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_bad++;
                $display("FAIL underflow: DUT state=%0d with no expected record", state);
            end else begin
                e   = exp_q.pop_front();
                got = {state, pc_we, ir_we, reg_we, mem_we, mdu_start, hilo_we, ri_exc,
                       npcop, extop, aluop, alusrc, regdst, memtoreg, hf, bt};
                if (got !== {e.st, e.stb, e.fld}) begin
                    n_bad++;
                    $display("FAIL cycle ins#%0d instr=%h: got st=%0d stb=%b fld=%b, required st=%0d stb=%b fld=%b",
                             e.tag, instr, got[23:21], got[20:14], got[13:0], e.st, e.stb, e.fld);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        fill_tab();
        @(posedge clk);
        #1;
        exp_q.push_back(mk(S_IF, 7'b0, 14'h0));
        running = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;

        run_instr(0,  32'h0022_1821, 1'b0, -1);   // addu $3,$1,$2
        run_instr(9,  32'h8C23_0004, 1'b0, -1);   // lw
        run_instr(12, 32'hAC23_0004, 1'b0, -1);   // sw
        run_instr(15, enc(15), 1'b1, -1);         // beq taken
        run_instr(15, enc(15), 1'b0, -1);         // beq not taken
        run_instr(21, 32'h0C00_0010, 1'b0, -1);   // jal
        run_instr(24, enc(24), 1'b0, -1);         // mult
        run_instr(26, enc(26), 1'b0, -1);         // div
        run_instr(24, enc(24), 1'b0, 5);          // mult, reset in 3rd S_MDU cycle
        run_instr(24, enc(24), 1'b0, -1);         // full mult after reset
        run_instr(12, enc(12), 1'b0, 3);          // sw, reset in S_MEM
        run_instr(28, 32'hFC00_0000, 1'b0, -1);   // reserved opcode
        run_instr(0,  enc(0), 1'b0, -1);

        for (int n = 0; n < 200; n++) begin
            int idx, ra;
            idx = $urandom_range(N_INS - 1, 0);
            ra  = ($urandom_range(15, 0) == 0) ? $urandom_range(6, 0) : -1;
            run_instr(idx, enc(idx), 1'($urandom_range(1, 0)), ra);
        end

        running = 1'b0;
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expected records left, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
